// File: rtl/rf_sched_pkg.sv
// Shared types and defaults for the register-file writeback scheduler.
package rf_sched_pkg;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } reqSel_t;

  localparam int NREG_DEF   = 16;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 2;

  function automatic logic [15:0] onehot16(input logic [3:0] id);
    return 16'h0001 << id;
  endfunction

endpackage

// File: rtl/rf_pend_counter.sv
// Pending-write counter for one register; never wraps in either direction.
module rf_pend_counter
  import rf_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             sat,
  output logic             zero
);

  assign sat  = &cnt;
  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && !dec && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the register file write port between ALU and load writeback,
// tracks pending writes per register and supplies same-cycle bypass data.
module rf_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [3:0]        alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [3:0]        mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              iss_valid,
  input  logic [3:0]        iss_reg,
  output logic              iss_ready,
  input  logic [3:0]        chk_reg1,
  input  logic [3:0]        chk_reg2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              byp1_hit,
  output logic [DATA_W-1:0] byp1_data,
  output logic              byp2_hit,
  output logic [DATA_W-1:0] byp2_data,
  output logic              rf_we,
  output logic [3:0]        rf_dst,
  output logic [DATA_W-1:0] rf_data,
  output logic              sb_err
);

  reqSel_t          rrLast;
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  sat;
  logic [NREG-1:0]  zero;
  logic [NREG-1:0]  incVec;
  logic [NREG-1:0]  decVec;
  logic             contended;

  assign contended = alu_valid && mem_valid;

  // Contended grant goes to whoever did not win last time.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (contended) begin
      if (rrLast == REQ_MEM) alu_ready = 1'b1;
      else                   mem_ready = 1'b1;
    end else begin
      alu_ready = alu_valid;
      mem_ready = mem_valid;
    end
  end

  always_comb begin
    rf_we   = alu_ready || mem_ready;
    rf_dst  = '0;
    rf_data = '0;
    if (alu_ready) begin
      rf_dst  = alu_reg;
      rf_data = alu_data;
    end else if (mem_ready) begin
      rf_dst  = mem_reg;
      rf_data = mem_data;
    end
  end

  assign iss_ready = !sat[iss_reg] || (rf_we && (rf_dst == iss_reg));
  assign incVec    = (iss_valid && iss_ready) ? NREG'(onehot16(iss_reg)) : '0;
  assign decVec    = rf_we ? NREG'(onehot16(rf_dst)) : '0;

  for (genvar g = 0; g < NREG; g++) begin : gen_cnt
    rf_pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (incVec[g]),
      .dec  (decVec[g]),
      .cnt  (cnt[g]),
      .sat  (sat[g]),
      .zero (zero[g])
    );
  end

  // Bypass only resolves the hazard when the completing write is the last one outstanding.
  assign byp1_hit  = rf_we && (rf_dst == chk_reg1) && (cnt[chk_reg1] == CNT_W'(1));
  assign byp2_hit  = rf_we && (rf_dst == chk_reg2) && (cnt[chk_reg2] == CNT_W'(1));
  assign byp1_data = rf_data;
  assign byp2_data = rf_data;
  assign hazard1   = !zero[chk_reg1] && !byp1_hit;
  assign hazard2   = !zero[chk_reg2] && !byp2_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rrLast <= REQ_MEM;
      sb_err <= 1'b0;
    end else begin
      if (contended) rrLast <= alu_ready ? REQ_ALU : REQ_MEM;
      if (rf_we && zero[rf_dst]) sb_err <= 1'b1;
    end
  end

endmodule
